// File: rtl/types_pkg.sv
// Shared types and constants for the instruction-fetch path.
package types_pkg;

  localparam int unsigned DATA_BUS    = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_BUS-1:0] instr;
    logic [31:0]         pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/ack side plus decode valid/ready/redirect side.
// fetch_misalign exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  import types_pkg::*;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_BUS-1:0]   mem_rdata;
  logic                  instr_valid;
  logic [DATA_BUS-1:0]   instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  logic                  PCsrc;
  logic [31:0]           ImmOp;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                  fetch_misalign;
`endif

  modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
    output fetch_misalign,
`endif
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_ack, mem_rdata, instr_ready, PCsrc, ImmOp
  );

  modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
    input  fetch_misalign,
`endif
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_ack, mem_rdata, instr_ready, PCsrc, ImmOp
  );

endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO with push/pop/flush; Depth must be a power of two.
// Head data is read straight from the storage registers.
module fetch_buffer #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW:0]    count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [PtrW:0]    cnt_q;
  logic             push_en, pop_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // Pop on empty is dropped; a push into a full buffer is only taken alongside a pop.
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_en) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (PtrW + 1)'(push_en) - (PtrW + 1)'(pop_en);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, one outstanding memory read, buffered output to decode.
// Define FETCH_MISALIGN_TRAP_EN to trap (rather than align down) misaligned redirect targets.
module fetch_unit
  import types_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           BUF_DEPTH  = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned EntryW = DATA_BUS + ADDR_WIDTH;
  localparam int unsigned CntW   = $clog2(BUF_DEPTH) + 1;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0] imm_ext, target_raw, target;
  logic                  pop, redirect, push, full, empty, space_after, trap, mem_req;
  logic [CntW-1:0]       count;
  logic [EntryW-1:0]     head;

  assign pop        = !empty && bus.instr_ready;
  assign redirect   = pop && bus.PCsrc;
  assign imm_ext    = ADDR_WIDTH'($signed(bus.ImmOp));
  assign target_raw = bus.instr_pc + imm_ext;
  assign push       = (state_q == REQ) && bus.mem_ack && !redirect;
  // A redirect flushes the buffer, so there is always room afterwards.
  assign space_after = redirect ||
                       ((int'(count) + int'(push) - int'(pop)) < int'(BUF_DEPTH));

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_now;

  assign target       = target_raw;
  assign misalign_now = redirect && (target_raw[1:0] != 2'b00);
  assign trap         = misalign_q || misalign_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else if (misalign_now) misalign_q <= 1'b1;
  end

  assign bus.fetch_misalign = misalign_q;
`else
  assign target = target_raw & ~ADDR_WIDTH'(INSTR_BYTES - 1);
  assign trap   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    mem_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) pc_d = target;
        if ((!full || pop) && !trap) state_d = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          pc_d    = redirect ? target : pc_q + ADDR_WIDTH'(INSTR_BYTES);
          state_d = (space_after && !trap) ? REQ : IDLE;
        end else if (redirect) begin
          // Request cannot be retracted: keep it up and drop its data when it lands.
          tgt_d   = target;
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          pc_d    = tgt_q;
          state_d = trap ? IDLE : REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  fetch_buffer #(
    .Width(EntryW),
    .Depth(BUF_DEPTH)
  ) u_buffer (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .data_i ({bus.mem_rdata, pc_q}),
    .pop_i  (pop),
    .flush_i(redirect),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = pc_q;
  assign bus.instr_valid = !empty;
  assign {bus.instr, bus.instr_pc} = head;

endmodule
